gauss_window_ctrl: RTL



---
 rtl/gauss_window_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gauss_window_ctrl.sv
// gauss_window_ctrl: window sequencer for the 3x3 Gaussian datapath.
// Define GAUSS_SOF_RESYNC_EN to add the sof input and sof_err output.
module gauss_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 10,
  parameter int IDX_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             lb_wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             win_shift,
  output logic [3:0]       corner_type,
  output logic [CNT_W-1:0] cen_row,
  output logic [CNT_W-1:0] cen_col,
`ifdef GAUSS_SOF_RESYNC_EN
  input  logic             sof,
  output logic             sof_err,
`endif
  output logic             frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LP_W   = IDX_W'(IMG_W);
  localparam logic [IDX_W-1:0] LP_WP2 = IDX_W'(IMG_W + 2);
  localparam logic [IDX_W-1:0] LP_N   = IDX_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] LP_L   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LP_B   = CNT_W'(IMG_H - 1);

  if (IMG_W * IMG_H >= (1 << IDX_W)) begin : g_idx_ovf
    $error("gauss_window_ctrl: IDX_W cannot hold IMG_W*IMG_H");
  end
  if (((IMG_W > IMG_H) ? IMG_W : IMG_H) > (1 << CNT_W)) begin : g_cnt_ovf
    $error("gauss_window_ctrl: CNT_W too narrow for the image size");
  end
  if (IMG_W < 3 || IMG_H < 3) begin : g_small
    $error("gauss_window_ctrl: image must be at least 3x3");
  end

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_in_idx;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_xfer;
  logic             w_eol;
  logic             w_last;
  logic [CNT_W-1:0] w_nrow;
  logic [CNT_W-1:0] w_ncol;
  logic [CNT_W-1:0] w_nr1;
  logic [CNT_W-1:0] w_nc1;
  logic [IDX_W-1:0] w_out_lin;
  logic [IDX_W-1:0] w_in_nxt;
  logic [IDX_W-1:0] w_need;
  logic             w_top;
  logic             w_bot;
  logic             w_lft;
  logic             w_rgt;
  logic             w_mid_r;
  logic             w_mid_c;
  logic [3:0]       w_corner;

  assign w_out_lin = IDX_W'(r_row) * LP_W + IDX_W'(r_col);

  // Throttle looks only at registered counters: no path from out_ready.
  assign in_ready = (r_state == S_RUN) &&
                    ((r_in_idx - w_out_lin) < LP_WP2);

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = r_out_valid & out_ready;
  assign w_eol    = (r_col == LP_L);
  assign w_last   = w_xfer && w_eol && (r_row == LP_B);

  assign w_ncol = !w_xfer ? r_col :
                  w_eol   ? '0    : r_col + CNT_W'(1);
  assign w_nrow = (w_xfer && w_eol) ? r_row + CNT_W'(1) : r_row;

  assign w_in_nxt = r_in_idx + IDX_W'(w_accept);

  // Highest raster index the next centre's window touches.
  assign w_nr1  = (w_nrow >= LP_B) ? LP_B : w_nrow + CNT_W'(1);
  assign w_nc1  = (w_ncol >= LP_L) ? LP_L : w_ncol + CNT_W'(1);
  assign w_need = IDX_W'(w_nr1) * LP_W + IDX_W'(w_nc1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_idx    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_last) begin
        r_state     <= S_DONE;
        r_in_idx    <= '0;
        r_row       <= '0;
        r_col       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_in_idx    <= w_in_nxt;
        r_row       <= w_nrow;
        r_col       <= w_ncol;
        r_out_valid <= (w_in_nxt > w_need);
        case (r_state)
          S_IDLE:  r_state <= S_RUN;
          S_RUN:   if (w_in_nxt == LP_N) r_state <= S_DRAIN;
          S_DONE:  r_state <= S_RUN;
          default: r_state <= r_state;
        endcase
      end
`ifdef GAUSS_SOF_RESYNC_EN
      if (w_accept && sof) begin
        r_state     <= S_RUN;
        r_in_idx    <= IDX_W'(1);
        r_row       <= '0;
        r_col       <= '0;
        r_out_valid <= 1'b0;
      end
`endif
    end
  end

`ifdef GAUSS_SOF_RESYNC_EN
  logic r_sof_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sof_err <= 1'b0;
    end else begin
      r_sof_err <= w_accept && sof && (r_in_idx != '0);
    end
  end

  assign sof_err = r_sof_err;
`endif

  assign w_top   = (r_row == '0);
  assign w_bot   = (r_row == LP_B);
  assign w_lft   = (r_col == '0);
  assign w_rgt   = (r_col == LP_L);
  assign w_mid_r = !w_top && !w_bot;
  assign w_mid_c = !w_lft && !w_rgt;

  always_comb begin
    w_corner = 4'd0;
    unique case (1'b1)
      !r_out_valid:                          w_corner = 4'd0;
      r_out_valid && w_top && w_lft:         w_corner = 4'd1;
      r_out_valid && w_top && w_rgt:         w_corner = 4'd2;
      r_out_valid && w_mid_r && w_lft:       w_corner = 4'd3;
      r_out_valid && w_mid_r && w_rgt:       w_corner = 4'd4;
      r_out_valid && w_bot && w_lft:         w_corner = 4'd5;
      r_out_valid && w_bot && w_rgt:         w_corner = 4'd6;
      r_out_valid && !w_mid_r && w_mid_c:    w_corner = 4'd7;
      r_out_valid && w_mid_r && w_mid_c:     w_corner = 4'd8;
      default:                               w_corner = 4'd0;
    endcase
  end

  assign out_valid   = r_out_valid;
  assign corner_type = w_corner;
  assign cen_row     = r_row;
  assign cen_col     = r_col;
  assign lb_wr_en    = w_accept;
  assign win_shift   = w_xfer;
  assign frame_done  = w_last;

endmodule
